// File: rtl/pair_chain_decoder.sv
// pair_chain_decoder
// Undoes DEPTH serial applications of the paired XOR/NOT primitive
// (o1 = a1 ^ a0, o0 = ~a0). Each inverse stage is one register stage.
// Stages are joined by a valid/ready pipeline whose ready chain is
// purely combinational, so empty stages (bubbles) collapse.
module pair_chain_decoder #(
  parameter int IO_PAIRS = 8,
  parameter int DEPTH    = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*IO_PAIRS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*IO_PAIRS-1:0] out_data,
  output logic [CNT_W-1:0]      word_count
);

  localparam int W = 2 * IO_PAIRS;

  logic [W-1:0]     stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] adv;
  logic             chain;

  // One inverse primitive across all pairs: a0 = ~o0, a1 = o1 ^ ~o0.
  function automatic logic [W-1:0] inverse_pair(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < IO_PAIRS; j++) begin
      r[2*j]   = ~d[2*j];
      r[2*j+1] = d[2*j+1] ^ ~d[2*j];
    end
    return r;
  endfunction

  // Backward advance chain: a stage may load when it is empty or its word leaves.
  always_comb begin
    adv   = '0;
    chain = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain  = !stage_valid[k] || chain;
      adv[k] = chain;
    end
  end

  assign in_ready  = rst_n && adv[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  // Stage registers; data only loads from a valid source so stray input never enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        stage_valid[0] <= in_valid;
        if (in_valid) begin
          stage_data[0] <= inverse_pair(in_data);
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          stage_valid[k] <= stage_valid[k-1];
          if (stage_valid[k-1]) begin
            stage_data[k] <= inverse_pair(stage_data[k-1]);
          end
        end
      end
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (out_valid && out_ready) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pair_chain_decoder.sv
// tb_pair_chain_decoder
// Directed vectors on DEPTH=1/2/4 instances, and a DEPTH=3 instance driven
// with random traffic that is checked against a queue-based model fed by
// a behavioural forward encoder.
module tb_pair_chain_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // Main DEPTH=3 instance
  logic        m_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_in_ready;
  logic        m_out_valid;
  logic [15:0] m_out_data;
  logic [15:0] m_count;

  // DEPTH=1, 4-bit counter instance
  logic        d1_valid = 1'b0;
  logic        d1_ready = 1'b1;
  logic [15:0] d1_data = '0;
  logic        d1_in_ready;
  logic        d1_out_valid;
  logic [15:0] d1_out_data;
  logic [3:0]  d1_count;

  // DEPTH=2 instance
  logic        d2_valid = 1'b0;
  logic [15:0] d2_data = '0;
  logic        d2_in_ready;
  logic        d2_out_valid;
  logic [15:0] d2_out_data;
  logic [15:0] d2_count;

  // DEPTH=4 instance
  logic        d4_valid = 1'b0;
  logic [15:0] d4_data = '0;
  logic        d4_in_ready;
  logic        d4_out_valid;
  logic [15:0] d4_out_data;
  logic [15:0] d4_count;

  pair_chain_decoder #(.IO_PAIRS(8), .DEPTH(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .in_ready(m_in_ready),
    .in_data(m_data), .out_valid(m_out_valid), .out_ready(m_ready),
    .out_data(m_out_data), .word_count(m_count)
  );

  pair_chain_decoder #(.IO_PAIRS(8), .DEPTH(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_valid), .in_ready(d1_in_ready),
    .in_data(d1_data), .out_valid(d1_out_valid), .out_ready(d1_ready),
    .out_data(d1_out_data), .word_count(d1_count)
  );

  pair_chain_decoder #(.IO_PAIRS(8), .DEPTH(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_valid), .in_ready(d2_in_ready),
    .in_data(d2_data), .out_valid(d2_out_valid), .out_ready(1'b1),
    .out_data(d2_out_data), .word_count(d2_count)
  );

  pair_chain_decoder #(.IO_PAIRS(8), .DEPTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(d4_valid), .in_ready(d4_in_ready),
    .in_data(d4_data), .out_valid(d4_out_valid), .out_ready(1'b1),
    .out_data(d4_out_data), .word_count(d4_count)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  int exp_count = 0;
  int accepted_total = 0;
  int delivered_total = 0;

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
    end
  endtask

  // Forward circuit, one primitive: per pair hi = a1 ^ a0, lo = ~a0.
  function automatic logic [15:0] fwd_once(input logic [15:0] a);
    logic [15:0] o;
    int p;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      p = int'((a >> (2 * j)) & 16'd3);
      o = o | (16'(((p >> 1) ^ p) & 1) << (2 * j + 1));
      o = o | (16'((~p) & 1) << (2 * j));
    end
    return o;
  endfunction

  function automatic logic [15:0] fwd3(input logic [15:0] a);
    return fwd_once(fwd_once(fwd_once(a)));
  endfunction

  // One cycle on the main instance: drive at negedge, check against the model, then update it.
  task automatic applyStimulus(input logic vld, input logic [15:0] orig, input logic rdy);
    logic acc;
    @(negedge clk);
    m_valid = vld;
    m_data  = vld ? fwd3(orig) : 16'($urandom);
    m_ready = rdy;
    #1;
    checkOutput("in_ready", 32'(m_in_ready), 32'((exp_q.size() < 3) || rdy));
    checkOutput("word_count", 32'(m_count), 32'(exp_count[15:0]));
    if (exp_q.size() == 0) begin
      checkOutput("idle_out_valid", 32'(m_out_valid), 32'd0);
    end else if (m_out_valid) begin
      checkOutput("out_data", 32'(m_out_data), 32'(exp_q[0]));
    end
    acc = vld && m_in_ready;
    if (m_out_valid && rdy && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_count++;
      delivered_total++;
    end
    if (acc) begin
      exp_q.push_back(orig);
      accepted_total++;
    end
  endtask

  initial begin
    logic [15:0] vin [4];
    logic [15:0] vout [4];
    int start_acc;
    int cycles;
    int sent;

    vin  = '{16'h5555, 16'hFFFF, 16'h0000, 16'hAAAA};
    vout = '{16'h0000, 16'hAAAA, 16'hFFFF, 16'h5555};

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(m_in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(m_out_valid), 32'd0);
    checkOutput("rst_count", 32'(m_count), 32'd0);
    checkOutput("rst_d1_in_ready", 32'(d1_in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(m_in_ready), 32'd1);

    // DEPTH=1 directed vectors, one edge of latency
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d1_valid = 1'b1;
      d1_data  = vin[i];
      #1 checkOutput("d1_in_ready", 32'(d1_in_ready), 32'd1);
      @(negedge clk);
      d1_valid = 1'b0;
      #1;
      checkOutput("d1_out_valid", 32'(d1_out_valid), 32'd1);
      checkOutput("d1_out_data", 32'(d1_out_data), 32'(vout[i]));
    end
    @(negedge clk);
    #1 checkOutput("d1_count4", 32'(d1_count), 32'd4);

    // DEPTH=1 counter wrap: 13 more deliveries makes 17, wrapping a 4-bit count to 1
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      d1_valid = 1'b1;
      d1_data  = 16'($urandom);
    end
    @(negedge clk);
    d1_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkOutput("d1_count_wrap", 32'(d1_count), 32'd1);

    // DEPTH=2: 0x0000 -> 0xAAAA after two edges
    @(negedge clk);
    d2_valid = 1'b1;
    d2_data  = 16'h0000;
    @(negedge clk);
    d2_valid = 1'b0;
    #1 checkOutput("d2_early_valid", 32'(d2_out_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("d2_out_valid", 32'(d2_out_valid), 32'd1);
    checkOutput("d2_out_data", 32'(d2_out_data), 32'hAAAA);
    @(negedge clk);
    #1 checkOutput("d2_count", 32'(d2_count), 32'd1);

    // DEPTH=4: four inverses are the identity
    @(negedge clk);
    d4_valid = 1'b1;
    d4_data  = 16'h1234;
    @(negedge clk);
    d4_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkOutput("d4_early_valid", 32'(d4_out_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("d4_out_valid", 32'(d4_out_valid), 32'd1);
    checkOutput("d4_out_data", 32'(d4_out_data), 32'h1234);
    @(negedge clk);
    #1 checkOutput("d4_count", 32'(d4_count), 32'd1);

    // Backpressure on DEPTH=3: exactly three words fit, then drain
    start_acc = accepted_total;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    checkOutput("bp_accepted", 32'(accepted_total - start_acc), 32'd3);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0, 1'b1);

    // Reset with two words in flight
    applyStimulus(1'b1, 16'h1357, 1'b0);
    applyStimulus(1'b1, 16'h2468, 1'b0);
    @(posedge clk);
    m_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(m_out_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(m_in_ready), 32'd0);
    checkOutput("mid_rst_count", 32'(m_count), 32'd0);
    checkOutput("mid_rst_out_data", 32'(m_out_data), 32'd0);
    exp_q.delete();
    exp_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("mid_release_in_ready", 32'(m_in_ready), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0, 1'b1);

    // Random round trip: 1000 words with random valid/ready
    delivered_total = 0;
    sent   = 0;
    cycles = 0;
    start_acc = accepted_total;
    while (delivered_total < 1000 && cycles < 20000) begin
      applyStimulus((sent < 1000) && ($urandom_range(3) != 0), 16'($urandom),
                    $urandom_range(3) != 0);
      sent = accepted_total - start_acc;
      cycles++;
    end
    checkOutput("rt_delivered", 32'(delivered_total), 32'd1000);
    @(negedge clk);
    #1 checkOutput("rt_word_count", 32'(m_count), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
